// File: rtl/prog_load_dump_pkg.sv
// prog_load_dump_pkg: shared types, constants and helpers for the program load/run/dump sequencer.
package prog_load_dump_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DUMP, S_DONE} state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_FIN} rd_phase_e;

    localparam logic [31:0] NOP_WORD = 32'h0;

    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] lim);
        return (len > lim) ? lim : len;
    endfunction

endpackage

// File: rtl/ldc_dump_reader.sv
// ldc_dump_reader: streams data-memory words 0..len-1 out through a valid/ready port, one word per two cycles.
module ldc_dump_reader
    import prog_load_dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DA_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DA_W:0]     len,
    output logic              finished,
    output logic [DA_W-1:0]   dmem_raddr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    rd_phase_e         ph_q, ph_d;
    logic [DA_W:0]     idx_q, len_q;
    logic              fresh_q;
    logic [DATA_W-1:0] hold_q;

    always_comb begin
        ph_d = ph_q;
        case (ph_q)
            RD_ADDR: ph_d = RD_DATA;
            RD_DATA: if (m_ready) ph_d = m_last ? RD_IDLE : RD_ADDR;
            RD_FIN:  ph_d = RD_IDLE;
            default: ph_d = ph_q;
        endcase
        if (start) ph_d = (len == '0) ? RD_FIN : RD_ADDR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q    <= RD_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            fresh_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ph_q    <= ph_d;
            fresh_q <= ph_q == RD_ADDR;
            if (fresh_q) hold_q <= dmem_rdata;
            if (start) begin
                idx_q <= '0;
                len_q <= len;
            end else if (m_valid && m_ready) begin
                idx_q <= idx_q + (DA_W+1)'(1);
            end
        end
    end

    // The read data is live only in the first data cycle; later stall cycles replay the captured copy.
    assign m_data     = fresh_q ? dmem_rdata : hold_q;
    assign m_valid    = ph_q == RD_DATA;
    assign m_last     = m_valid && (idx_q == len_q - (DA_W+1)'(1));
    assign dmem_raddr = idx_q[DA_W-1:0];
    assign finished   = (ph_q == RD_FIN) || (m_valid && m_ready && m_last);

endmodule

// File: rtl/prog_load_dump_ctrl.sv
// prog_load_dump_ctrl: loads imem from a stream with the core held in reset, runs it for a budget, dumps dmem.
// Define LDC_IMEM_CLEAR_EN to zero-fill the unloaded tail of imem before the run.
module prog_load_dump_ctrl
    import prog_load_dump_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int RUN_W      = 16,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IA_W:0]     load_len,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic [DA_W:0]     dump_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              imem_we,
    output logic [IA_W-1:0]   imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic [DA_W-1:0]   dmem_raddr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [IA_W:0] IMEM_FULL = (IA_W+1)'(IMEM_DEPTH);

    state_e            state_q, state_d;
    logic [IA_W:0]     cnt_q, load_len_q;
    logic [DA_W:0]     dump_len_q;
    logic [RUN_W-1:0]  run_q;
    logic              imem_we_q;
    logic [IA_W-1:0]   imem_addr_q;
    logic [DATA_W-1:0] imem_wdata_q;
    logic              load_done, load_wr, clr_wr, dump_start, dump_fin;

    assign load_done = cnt_q == load_len_q;
    assign load_wr   = s_valid && s_ready;
`ifdef LDC_IMEM_CLEAR_EN
    assign clr_wr    = (state_q == S_CLEAR) && (cnt_q != IMEM_FULL);
`else
    assign clr_wr    = 1'b0;
`endif
    assign dump_start = (state_q == S_RUN) && (state_d == S_DUMP);

    always_ff @(posedge clk) state_q <= reset ? S_IDLE : state_d;

    // Leaving LOAD/CLEAR waits for the counter to settle, so the final write lands before the core runs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
`ifdef LDC_IMEM_CLEAR_EN
            S_LOAD:  if (load_done) state_d = (cnt_q == IMEM_FULL) ? S_RUN : S_CLEAR;
            S_CLEAR: if (cnt_q == IMEM_FULL) state_d = S_RUN;
`else
            S_LOAD:  if (load_done) state_d = S_RUN;
`endif
            S_RUN:   if (run_q <= RUN_W'(1)) state_d = S_DUMP;
            S_DUMP:  if (dump_fin) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != S_IDLE;
        done      = state_q == S_DONE;
        cpu_reset = !((state_q == S_RUN) && (run_q != '0));
        s_ready   = (state_q == S_LOAD) && !load_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            load_len_q   <= '0;
            dump_len_q   <= '0;
            run_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            imem_we_q <= load_wr || clr_wr;
            if (load_wr || clr_wr) begin
                imem_addr_q  <= cnt_q[IA_W-1:0];
                imem_wdata_q <= load_wr ? s_data : DATA_W'(NOP_WORD);
                cnt_q        <= cnt_q + (IA_W+1)'(1);
            end
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
                if (start) begin
                    load_len_q <= (IA_W+1)'(clamp_len(32'(load_len), 32'(IMEM_DEPTH)));
                    dump_len_q <= (DA_W+1)'(clamp_len(32'(dump_len), 32'(DMEM_DEPTH)));
                    run_q      <= run_cycles;
                end
            end
            if ((state_q == S_RUN) && (run_q != '0)) run_q <= run_q - RUN_W'(1);
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

    ldc_dump_reader #(.DATA_W(DATA_W), .DA_W(DA_W)) u_reader (
        .clk        (clk),
        .reset      (reset),
        .start      (dump_start),
        .len        (dump_len_q),
        .finished   (dump_fin),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// tb_prog_load_dump_ctrl: scoreboard bench for the load/run/dump sequencer (imem writes and dump words).
module tb_prog_load_dump_ctrl;

    localparam int IA_W = 6, DA_W = 6, DATA_W = 32, RUN_W = 16;

    logic              clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [IA_W:0]     load_len = '0;
    logic [RUN_W-1:0]  run_cycles = '0;
    logic [DA_W:0]     dump_len = '0;
    logic              s_valid = 1'b0, s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              imem_we, cpu_reset, m_valid, m_ready = 1'b1, m_last, busy, done;
    logic [IA_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_wdata, m_data, dmem_rdata = '0;
    logic [DA_W-1:0]   dmem_raddr;

    always #5 clk = ~clk;

    prog_load_dump_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len), .run_cycles(run_cycles),
        .dump_len(dump_len), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
    );

    logic [31:0] dmem [64];
    always @(posedge clk) dmem_rdata <= dmem[dmem_raddr];

    int          n_checks = 0, n_errors = 0;
    int          exp_addr[$];
    logic [31:0] exp_wdata[$], exp_dout[$];
    bit          exp_dlast[$];
    int          we_cnt, low_cnt, done_cnt, busy_cnt, dump_seen, stall_left, stall_obs;
    bit          stalled_prev = 1'b0;
    logic [31:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (!cpu_reset) low_cnt++;
            if (done) done_cnt++;
            if (imem_we) begin
                we_cnt++;
                check("imem_we_with_core_running", 64'(cpu_reset), 64'd1);
                if (exp_addr.size() == 0) check("imem_extra_write", 64'(imem_we), 64'd0);
                else begin
                    check("imem_addr", 64'(imem_addr), 64'(exp_addr.pop_front()));
                    check("imem_wdata", 64'(imem_wdata), 64'(exp_wdata.pop_front()));
                end
            end
            if (m_valid && m_ready) begin
                dump_seen++;
                if (exp_dout.size() == 0) check("dump_extra_word", 64'(m_valid), 64'd0);
                else begin
                    check("m_data", 64'(m_data), 64'(exp_dout.pop_front()));
                    check("m_last", 64'(m_last), 64'(exp_dlast.pop_front()));
                end
            end
            if (m_valid && !m_ready) begin
                stall_obs++;
                if (stalled_prev) check("m_data_hold", 64'(m_data), 64'(held));
                held = m_data;
                stalled_prev = 1'b1;
            end else stalled_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && m_valid && dump_seen == 3) begin
            m_ready = 1'b0;
            stall_left--;
        end else m_ready = 1'b1;
    end

    task automatic push_clear(input int nl);
`ifdef LDC_IMEM_CLEAR_EN
        for (int a = nl; a < 64; a++) begin
            exp_addr.push_back(a);
            exp_wdata.push_back(32'h0);
        end
`endif
    endtask

    task automatic session(input int ll, input int rc, input int dl, input bit st_load, input bit st_dump);
        int nl = (ll > 64) ? 64 : ll;
        int nd = (dl > 64) ? 64 : dl;
        int nclr = 0;
        int k = 0, g = 0;
`ifdef LDC_IMEM_CLEAR_EN
        nclr = 64 - nl;
`endif
        for (int i = 0; i < nd; i++) begin
            exp_dout.push_back(dmem[i]);
            exp_dlast.push_back(i == nd - 1);
        end
        we_cnt = 0; low_cnt = 0; done_cnt = 0; busy_cnt = 0; dump_seen = 0; stall_obs = 0;
        stall_left = st_dump ? 5 : 0;
        @(posedge clk); #1;
        load_len = (IA_W+1)'(ll); run_cycles = RUN_W'(rc); dump_len = (DA_W+1)'(dl); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_len = (IA_W+1)'($urandom_range(0, 127));
        run_cycles = RUN_W'($urandom_range(0, 999));
        dump_len = (DA_W+1)'($urandom_range(0, 127));
        @(negedge clk);
        check("s_ready_after_start", 64'(s_ready), 64'(nl > 0));
        while (k < nl && g < 2000) begin
            @(posedge clk); #1;
            s_valid = st_load ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = $urandom;
            @(negedge clk);
            g++;
            if (s_valid && s_ready) begin
                exp_addr.push_back(k);
                exp_wdata.push_back(s_data);
                k++;
            end
        end
        check("load_handshakes", 64'(k), 64'(nl));
        @(posedge clk); #1;
        s_valid = 1'b0;
        push_clear(nl);
        g = 0;
        while (done_cnt == 0 && g < 20000) begin
            @(negedge clk); #1;
            g++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
        check("imem_write_count", 64'(we_cnt), 64'(nl + nclr));
        check("imem_pending", 64'(exp_addr.size()), 64'd0);
        check("cpu_reset_low_cycles", 64'(low_cnt), 64'(rc));
        check("dump_word_count", 64'(dump_seen), 64'(nd));
        check("dump_pending", 64'(exp_dout.size()), 64'd0);
        check("done_pulse_cycles", 64'(done_cnt), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        if (st_dump) check("dump_stall_cycles", 64'(stall_obs), 64'(nd > 3 ? 5 : 0));
    endtask

    initial begin
        int g = 0;
        int exp_busy = 4;
        for (int i = 0; i < 64; i++) dmem[i] = 32'hC0DE0000 + 32'(i) * 32'h00010003;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        session(10, 50, 11, 1'b0, 1'b0);
        session(16, 5, 8, 1'b1, 1'b1);
        session(0, 0, 0, 1'b0, 1'b0);
`ifdef LDC_IMEM_CLEAR_EN
        exp_busy = 4 + 65;
`endif
        check("zero_len_busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        session(70, 3, 70, 1'b0, 1'b0);

        we_cnt = 0; low_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        load_len = '0; run_cycles = RUN_W'(100); dump_len = (DA_W+1)'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_clear(0);
        while (low_cnt < 20 && g < 2000) begin
            @(negedge clk); #1;
            g++;
        end
        check("reset_test_run_cycle_20", 64'(low_cnt), 64'd20);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_cpu_reset", 64'(cpu_reset), 64'd1);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_m_valid", 64'(m_valid), 64'd0);
        check("midrun_reset_imem_we", 64'(imem_we), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun_reset_no_done", 64'(done_cnt), 64'd0);
        check("midrun_reset_run_stopped", 64'(low_cnt), 64'd20);
        check("midrun_reset_imem_pending", 64'(exp_addr.size()), 64'd0);

        session(5, 7, 4, 1'b0, 1'b0);
`ifdef LDC_IMEM_CLEAR_EN
        session(4, 10, 4, 1'b0, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_load_dump_ctrl.md
# prog_load_dump_ctrl

Synthesisable session sequencer for the MIPS core: loads a program into instruction memory from a valid/ready stream while holding the core in reset, releases the core for a programmable number of cycles, then streams out a programmable window of data memory. It sits beside `mips_top`, driving its reset and the instruction-memory write port, and reading the data memory through a dedicated read port. Depths, data width and run budget are parameters.

## Interface
- `DATA_W`, 32, instruction and data word width
- `IMEM_DEPTH`, 64, instruction memory words; `IA_W = $clog2(IMEM_DEPTH)`
- `DMEM_DEPTH`, 64, data memory words; `DA_W = $clog2(DMEM_DEPTH)`
- `RUN_W`, 16, width of the run-cycle budget
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin session; sampled only in IDLE
- `load_len`  in  IA_W+1  instruction words to load; values above IMEM_DEPTH are clamped to it
- `run_cycles`  in  RUN_W  cycles the core runs out of reset
- `dump_len`  in  DA_W+1  data words to dump from address 0; values above DMEM_DEPTH are clamped
- `s_valid` in 1, `s_ready` out 1, `s_data` in DATA_W: program stream
- `imem_we` out 1, `imem_addr` out IA_W, `imem_wdata` out DATA_W: instruction-memory write port
- `cpu_reset`  out  1  reset to the core
- `dmem_raddr` out DA_W, `dmem_rdata` in DATA_W: data-memory read port, 1-cycle synchronous latency
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_W, `m_last` out 1: dump stream
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at session end

## Operation
- States: IDLE -> LOAD -> (CLEAR) -> RUN -> DUMP -> DONE -> IDLE.
- `cpu_reset` is 1 in every state except RUN.
- IDLE: `start`=1 latches `load_len`, `run_cycles`, `dump_len` (clamped); next state is LOAD. Input changes after latching are ignored.
- LOAD: `s_ready`=1 until `load_len` words are accepted. Word k (0-based) is written to address k. With `load_len`=0, LOAD lasts exactly one cycle.
- CLEAR: present only with the macro (see Configuration).
- RUN: `cpu_reset`=0 for exactly `run_cycles` cycles. With `run_cycles`=0, RUN lasts one cycle and `cpu_reset` stays 1.
- DUMP: for i = 0..dump_len-1, `dmem_raddr`=i is driven for one cycle. On the next cycle `m_data` <= `dmem_rdata` and `m_valid`=1. `m_valid`/`m_data` are held stable until `m_ready`. `m_last`=1 with word dump_len-1. With `dump_len`=0, DUMP lasts one cycle and emits nothing.
- DONE: `done`=1 for one cycle; next state is IDLE.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, all other outputs 0.
- `reset` mid-session: next cycle returns to IDLE with reset values. No partial write is issued after the reset edge. An in-flight dump word is dropped.
- `start` at edge t gives LOAD at t+1, with `s_ready`=1 from t+1.
- Load write is registered: a handshake at edge t gives `imem_we`=1 with that address/data during cycle t+1.
- `s_ready` falls in the cycle after the last handshake. The first RUN (or CLEAR) cycle follows the last `imem_we` cycle, so no write overlaps `cpu_reset`=0.
- Dump throughput is at most one word per 2 cycles: address cycle, then a data cycle held under backpressure. The next address is issued the cycle after the `m_valid && m_ready` handshake.
- `done` rises 1 cycle after the final dump handshake.
- Counter widths: the load and dump indices carry one extra bit so that a count equal to the depth terminates without wrap. The run counter is RUN_W bits and does not wrap.

## Configuration
- `LDC_IMEM_CLEAR_EN` defined:
  - After LOAD, the CLEAR state writes zeros (MIPS NOP) to addresses load_len..IMEM_DEPTH-1, one per cycle, `s_ready`=0.
  - CLEAR is skipped if load_len = IMEM_DEPTH.
- Not defined:
  - CLEAR does not exist; LOAD goes directly to RUN.
  - Unloaded words keep stale contents.

## Structure
- Package `prog_load_dump_pkg`: state enum, clamp helper function, and `NOP_WORD = 32'h0`.
- One sub-module `ldc_dump_reader`: owns `dmem_raddr`, the 1-cycle read alignment, the hold under backpressure, and `m_last`. Interface: start/len/finished.
- The top-level owns the FSM, load/clear addressing and the run counter.

## Test plan
- Load 10 words (`load_len`=10), `run_cycles`=50, `dump_len`=11:
  - 10 `imem_we` pulses at addresses 0..9.
  - `cpu_reset` low for exactly 50 cycles.
  - 11 words out, `m_last` on the 11th, `done` pulse.
- Stall `s_valid` randomly during load, and hold `m_ready`=0 for 5 cycles on dump word 3: no lost or duplicated words, and `m_data` is stable while stalled.
- `load_len`=0, `run_cycles`=0, `dump_len`=0 gives IDLE->LOAD->RUN->DUMP->DONE in 4 cycles with `cpu_reset` never low.
- `load_len`=70 with IMEM_DEPTH=64 is clamped: 64 writes, last address 63, no wrap to 0.
- Assert `reset` during RUN cycle 20: `cpu_reset`=1 and IDLE on the next cycle, no `done`. A fresh `start` then completes normally.
- With `LDC_IMEM_CLEAR_EN`, `load_len`=4: writes to 0..3 with data, then 60 zero writes at addresses 4..63, then RUN.
